inner_product_checker: RTL and testbench
========================================

// Module: inner_product_checker
// PURPOSE
//  Receiving end of the inner-product stimulus interface: takes an operand pair (inp1, inp2)
//  and the inner_product DUT result, recomputes the reference sum serially with one MAC per
//  cycle, and compares. Sits beside the DUT in self-checking harnesses; exports match/error
//  status and running counts for the bench or for on-chip debug.
// PARAMETERS
//  N    4   number of elements per vector
//  DW   8   element width and DUT result width
//  CW   16  width of check_count / err_count
// PORTS
//  clk          in   1     single clock, rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  in_valid     in   1     operand pair + DUT result presented
//  in_ready     out  1     checker idle, can accept
//  inp1         in   N*DW  vector A, element i = inp1[i*DW +: DW]
//  inp2         in   N*DW  vector B, same packing
//  dut_outp     in   DW    DUT result to be checked
//  done         out  1     one-cycle pulse: comparison result valid
//  match        out  1     last comparison passed (valid when done; holds afterwards)
//  expected     out  DW    last reference result, low DW bits
//  err_sticky   out  1     set on any mismatch, cleared only by reset
//  check_count  out  CW    completed comparisons, saturating
//  err_count    out  CW    mismatches, saturating
// BEHAVIOUR
//  - Reset (async on rst_n low): state=IDLE; in_ready=1; done=0, match=0, expected=0,
//    err_sticky=0, both counts 0; accumulator, index and captured operands cleared.
//    Reset mid-operation abandons the transaction; no done pulse and no count update.
//  - Handshake: accept when in_valid && in_ready at a rising edge; inp1, inp2, dut_outp are
//    captured at that edge. in_valid while busy is ignored (not queued); in_ready is
//    registered and equals (state==IDLE).
//  - FSM: IDLE --accept--> ACCUM (idx=0, acc=0).
//    ACCUM: each edge acc += A[idx]*B[idx] (unsigned, DW x DW -> 2*DW), idx++;
//    after the edge that adds idx=N-1 -> CMP.
//    CMP: one edge; updates done/match/expected/counters/err_sticky; -> IDLE.
//  - Accumulator width 2*DW+clog2(N); no overflow internally. Reference = acc[DW-1:0]
//    (DUT result is modulo 2^DW); match = (acc[DW-1:0] == captured dut_outp).
//  - Latency: accept at edge E0 -> done high for the cycle after edge E0+N+1.
//    in_ready returns high with done; the next accept is possible at edge E0+N+2
//    (throughput 1 per N+2 cycles).
//  - Counters: check_count+1 per CMP; err_count+1 on mismatch; both saturate at 2^CW-1.
//  - done is 0 in all cycles except the single CMP-result cycle.
// TESTING (N=4, DW=8 unless stated)
//  1. inp1=inp2=32'h04030201, dut_outp=8'h1E -> done after 5 edges, match=1,
//     expected=8'h1E, check_count=1, err_count=0.
//  2. inp1=inp2=32'hFFFFFFFF, dut_outp=8'h04 -> wrap: 4*65025=260100, expected=8'h04, match=1.
//  3. Case 1 with dut_outp=8'h1F -> match=0, err_count=1, err_sticky=1; a following passing
//     check leaves err_sticky=1 and err_count=1.
//  4. Hold in_valid high with changing data -> accepts only at edges where in_ready=1;
//     back-to-back checks spaced 6 edges apart, each result correct for its captured data.
//  5. Drop rst_n two cycles into ACCUM -> all outputs zero immediately, in_ready=1,
//     no done pulse; a new check afterwards computes correctly.
//  6. CW=2, four mismatching checks -> err_count and check_count stick at 3.

Source files
------------

// File: rtl/inner_product_checker.sv
// Serial inner-product reference checker: captures an operand pair plus the DUT result,
// recomputes the sum with one MAC per cycle and reports match status and running counts.
module inner_product_checker #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] inp1,
  input  logic [N*DW-1:0] inp2,
  input  logic [DW-1:0]   dut_outp,
  output logic            done,
  output logic            match,
  output logic [DW-1:0]   expected,
  output logic            err_sticky,
  output logic [CW-1:0]   check_count,
  output logic [CW-1:0]   err_count
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = 2*DW + $clog2(N);

  typedef enum logic [1:0] {IDLE, ACCUM, CMP} state_t;

  state_t            state, state_next;
  logic [N*DW-1:0]   a_q, b_q;
  logic [DW-1:0]     dut_q;
  logic [AW-1:0]     acc;
  logic [IW-1:0]     idx;
  logic [DW-1:0]     a_el, b_el;
  logic [2*DW-1:0]   prod;
  logic              accept, last_idx, mismatch;

  assign accept   = in_valid && in_ready;
  assign last_idx = (idx == IW'(N-1));
  assign a_el     = a_q[idx*DW +: DW];
  assign b_el     = b_q[idx*DW +: DW];
  assign prod     = (2*DW)'(a_el) * (2*DW)'(b_el);
  // The DUT result is modulo 2^DW, so only the low bits of the reference are compared.
  assign mismatch = (acc[DW-1:0] != dut_q);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)   state_next = ACCUM;
      ACCUM:   if (last_idx) state_next = CMP;
      CMP:                   state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b1;
    end else begin
      state    <= state_next;
      in_ready <= (state_next == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      dut_q <= '0;
      acc   <= '0;
      idx   <= '0;
    end else if (accept) begin
      a_q   <= inp1;
      b_q   <= inp2;
      dut_q <= dut_outp;
      acc   <= '0;
      idx   <= '0;
    end else if (state == ACCUM) begin
      acc <= acc + AW'(prod);
      idx <= last_idx ? '0 : idx + IW'(1);
    end
  end

  // Status is only touched in CMP, so an abandoned transaction never reaches the counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= 1'b0;
      match       <= 1'b0;
      expected    <= '0;
      err_sticky  <= 1'b0;
      check_count <= '0;
      err_count   <= '0;
    end else begin
      done <= 1'b0;
      if (state == CMP) begin
        done     <= 1'b1;
        match    <= !mismatch;
        expected <= acc[DW-1:0];
        if (check_count != '1)
          check_count <= check_count + CW'(1);
        if (mismatch) begin
          err_sticky <= 1'b1;
          if (err_count != '1)
            err_count <= err_count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_inner_product_checker.sv
// Directed table-driven bench for inner_product_checker; a second CW=2 instance sharing
// the same stimulus exercises counter saturation.
module tb_inner_product_checker;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] inp1, inp2;
  logic [7:0]  dut_outp;

  logic        in_ready, done, match, err_sticky;
  logic [7:0]  expected;
  logic [15:0] check_count, err_count;

  logic        in_ready_s, done_s, match_s, err_sticky_s;
  logic [7:0]  expected_s;
  logic [1:0]  check_count_s, err_count_s;

  int checks = 0;
  int errors = 0;
  int exp_checks, exp_errs;
  logic exp_sticky;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  dut;
    logic [7:0]  exp;
    logic        m;
  } vec_t;

  vec_t tbl[8];

  inner_product_checker #(.N(4), .DW(8), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inp1(inp1), .inp2(inp2), .dut_outp(dut_outp), .done(done), .match(match),
    .expected(expected), .err_sticky(err_sticky), .check_count(check_count),
    .err_count(err_count)
  );

  inner_product_checker #(.N(4), .DW(8), .CW(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .inp1(inp1), .inp2(inp2), .dut_outp(dut_outp), .done(done_s), .match(match_s),
    .expected(expected_s), .err_sticky(err_sticky_s), .check_count(check_count_s),
    .err_count(err_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called in the done cycle: advance the reference counts and compare every status output.
  task automatic noteResult(input vec_t v);
    exp_checks++;
    if (!v.m) begin
      exp_errs++;
      exp_sticky = 1'b1;
    end
    checkOutput("match", match, v.m);
    checkOutput("expected", expected, v.exp);
    checkOutput("check_count", check_count, exp_checks);
    checkOutput("err_count", err_count, exp_errs);
    checkOutput("err_sticky", err_sticky, exp_sticky);
    checkOutput("ready_with_done", in_ready, 1);
    checkOutput("check_count_sat", check_count_s, sat3(exp_checks));
    checkOutput("err_count_sat", err_count_s, sat3(exp_errs));
  endtask

  // Entered and left at a falling edge; one complete transaction with latency checking.
  task automatic applyStimulus(input vec_t v);
    int  k;
    bit  seen;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("ready_before", in_ready, 1);
    inp1 = v.a; inp2 = v.b; dut_outp = v.dut; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    inp1 = $urandom; inp2 = $urandom; dut_outp = 8'($urandom);
    checkOutput("ready_busy", in_ready, 0);
    k = 0;
    seen = 0;
    while (!seen && k < 12) begin
      @(negedge clk);
      k++;
      if (done) seen = 1;
    end
    checkOutput("latency", k, 5);
    if (seen) noteResult(v);
    @(negedge clk);
    checkOutput("done_pulse", done, 0);
  endtask

  initial begin
    int   sent, got, cyc, last_acc, sel[3];
    vec_t pend[$];
    vec_t cur;
    bit   saw_done;

    tbl[0] = '{32'h04030201, 32'h04030201, 8'h1E, 8'h1E, 1'b1};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 8'h04, 8'h04, 1'b1};
    tbl[2] = '{32'h04030201, 32'h04030201, 8'h1F, 8'h1E, 1'b0};
    tbl[3] = '{32'h04030201, 32'h01010101, 8'h0A, 8'h0A, 1'b1};
    tbl[4] = '{32'h0A0B0C0D, 32'h02020202, 8'h5C, 8'h5C, 1'b1};
    tbl[5] = '{32'h10101010, 32'h10101010, 8'h00, 8'h00, 1'b1};
    tbl[6] = '{32'h00000000, 32'hFFFFFFFF, 8'h01, 8'h00, 1'b0};
    tbl[7] = '{32'h80402010, 32'h02040810, 8'h00, 8'h00, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; inp1 = '0; inp2 = '0; dut_outp = '0;
    exp_checks = 0; exp_errs = 0; exp_sticky = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_match", match, 0);
    checkOutput("rst_expected", expected, 0);
    checkOutput("rst_sticky", err_sticky, 0);
    checkOutput("rst_check_count", check_count, 0);
    checkOutput("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic pass, wrap, mismatch then pass (sticky must hold), then the rest of the table.
    applyStimulus(tbl[0]);
    applyStimulus(tbl[1]);
    applyStimulus(tbl[2]);
    applyStimulus(tbl[0]);
    for (int i = 3; i < 8; i++) applyStimulus(tbl[i]);

    // in_valid held high: data changes every cycle, only ready edges may accept.
    sel[0] = 1; sel[1] = 3; sel[2] = 4;
    sent = 0; got = 0; cyc = 0; last_acc = -1;
    in_valid = 1'b1;
    while (got < 3 && cyc < 60) begin
      if (done) begin
        cur = pend.pop_front();
        noteResult(cur);
        got++;
      end
      if (in_ready && sent < 3) begin
        cur = tbl[sel[sent]];
        inp1 = cur.a; inp2 = cur.b; dut_outp = cur.dut;
        pend.push_back(cur);
        if (last_acc >= 0) checkOutput("b2b_spacing", cyc - last_acc, 6);
        last_acc = cyc;
        sent++;
      end else begin
        inp1 = $urandom; inp2 = $urandom; dut_outp = 8'($urandom);
        if (sent >= 3) in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("b2b_completed", got, 3);
    @(negedge clk);

    // Reset two cycles into ACCUM abandons the check.
    inp1 = tbl[0].a; inp2 = tbl[0].b; dut_outp = tbl[0].dut; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_checks = 0; exp_errs = 0; exp_sticky = 1'b0;
    checkOutput("mid_rst_in_ready", in_ready, 1);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_match", match, 0);
    checkOutput("mid_rst_expected", expected, 0);
    checkOutput("mid_rst_sticky", err_sticky, 0);
    checkOutput("mid_rst_check_count", check_count, 0);
    checkOutput("mid_rst_err_count", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    checkOutput("no_done_after_rst", saw_done, 0);
    applyStimulus(tbl[0]);

    // Four mismatches drive the CW=2 counters into saturation.
    applyStimulus(tbl[2]);
    applyStimulus(tbl[6]);
    applyStimulus(tbl[2]);
    applyStimulus(tbl[6]);
    checkOutput("final_err_count", err_count, 4);
    checkOutput("final_err_count_sat", err_count_s, 3);
    checkOutput("final_check_count_sat", check_count_s, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
